// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//   Shares one combinational shifter between two requesters (port 0: integer
//   execute path, port 1: CSR/bit-manip helper). An accepted operation is
//   shifted in the accept cycle and captured into a one-entry response
//   buffer tagged with the issuing port.
//
//   Build option: SHIFT_ARB_RR_EN
//     defined   -> round-robin between the two ports on ties
//     undefined -> fixed priority, port 0 always wins ties (no pointer reg)
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   reqN_valid/reqN_ready    request handshake for port N (N = 0,1)
//   reqN_ctrl                00 LSL, 01 LSR, 10 ASR, 11 rotate-right
//   reqN_shamt               shift amount (5 bits)
//   reqN_data                operand
//   rsp_valid/rsp_ready      response handshake
//   rsp_data                 shifted result
//   rsp_id                   port that issued the result
// ---------------------------------------------------------------------------
module shift_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_ctrl,
  input  logic [4:0]       req0_shamt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_ctrl,
  input  logic [4:0]       req1_shamt,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t       state;
  logic             can_accept;
  logic             gnt_any;
  logic             gnt;       // winning port when gnt_any
  logic             accept;
  logic [1:0]       sel_ctrl;
  logic [4:0]       sel_shamt;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] shift_out;

  function automatic logic [WIDTH-1:0] do_shift(
    input logic [1:0]       op,
    input logic [4:0]       sh,
    input logic [WIDTH-1:0] d
  );
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   r;
    dd = {d, d} >> sh;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = $unsigned($signed(d) >>> sh);
      default: r = dd[WIDTH-1:0];
    endcase
    return r;
  endfunction

  assign rsp_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) || rsp_ready;
  assign gnt_any    = req0_valid || req1_valid;

`ifdef SHIFT_ARB_RR_EN
  logic last_gnt;  // port granted most recently; reset to 1 so port 0 wins first tie
  assign gnt = (req0_valid && req1_valid) ? ~last_gnt : ~req0_valid;
`else
  assign gnt = ~req0_valid;
`endif

  // rst_n gating keeps both readies low throughout reset
  assign accept     = rst_n && can_accept && gnt_any;
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept &&  gnt;

  assign sel_ctrl  = gnt ? req1_ctrl  : req0_ctrl;
  assign sel_shamt = gnt ? req1_shamt : req0_shamt;
  assign sel_data  = gnt ? req1_data  : req0_data;
  assign shift_out = do_shift(sel_ctrl, sel_shamt, sel_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
      last_gnt <= 1'b1;
`endif
    end else if (accept) begin
      // covers EMPTY->FULL and pop+accept (FULL->FULL, no bubble)
      state    <= FULL;
      rsp_data <= shift_out;
      rsp_id   <= gnt;
`ifdef SHIFT_ARB_RR_EN
      last_gnt <= gnt;
`endif
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_ctrl, req1_ctrl;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [31:0] req0_data, req1_data;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int total = 0;
  int bad   = 0;

  shift_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_shamt(req0_shamt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_shamt(req1_shamt), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp_chk(input string tag, input logic [31:0] d, input logic id);
    check({tag, ".v"},  {31'b0, rsp_valid}, 32'd1);
    check({tag, ".d"},  rsp_data, d);
    check({tag, ".id"}, {31'b0, rsp_id}, {31'b0, id});
  endtask

  // single op on port 0 with port 1 idle, rsp_ready high
  task automatic issue0(input string tag, input logic [1:0] c, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] exp);
    req0_valid = 1'b1; req0_ctrl = c; req0_shamt = s; req0_data = d;
    req1_valid = 1'b0;
    #1;
    check({tag, ".rdy"}, {31'b0, req0_ready}, 32'd1);
    tick();
    rsp_chk(tag, exp, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_ctrl = 2'b00; req0_shamt = 5'd4; req0_data = 32'h8000_00F1;
    req1_valid = 1'b1; req1_ctrl = 2'b00; req1_shamt = 5'd0; req1_data = 32'h2222_2222;

    // reset with both valids high
    tick();
    check("rst.rdy0", {31'b0, req0_ready}, 32'd0);
    check("rst.rdy1", {31'b0, req1_ready}, 32'd0);
    tick();
    check("rst.v",    {31'b0, rsp_valid}, 32'd0);
    check("rst.d",    rsp_data, 32'd0);
    check("rst.id",   {31'b0, rsp_id}, 32'd0);
    check("rst.rdy0b", {31'b0, req0_ready}, 32'd0);
    check("rst.rdy1b", {31'b0, req1_ready}, 32'd0);

    // release: port 0 wins the first tie in both builds (LSL 0x800000F1 by 4)
    rst_n = 1'b1;
    #1;
    check("rel.rdy0", {31'b0, req0_ready}, 32'd1);
    check("rel.rdy1", {31'b0, req1_ready}, 32'd0);
    tick();
    rsp_chk("lsl4", 32'h0000_0F10, 1'b0);

    // remaining ops, shamt=4
    issue0("lsr4", 2'b01, 5'd4, 32'h8000_00F1, 32'h0800_000F);
    issue0("asr4", 2'b10, 5'd4, 32'h8000_00F1, 32'hF800_000F);
    issue0("ror4", 2'b11, 5'd4, 32'h8000_00F1, 32'h1800_000F);
    // shamt=0 is identity for every op
    issue0("lsl0", 2'b00, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue0("lsr0", 2'b01, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue0("asr0", 2'b10, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue0("ror0", 2'b11, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // single port-1 op: granted regardless of pointer, leaves pointer at 1
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctrl = 2'b00; req1_shamt = 5'd8; req1_data = 32'h0000_00AB;
    #1;
    check("p1.rdy", {31'b0, req1_ready}, 32'd1);
    tick();
    rsp_chk("p1lsl8", 32'h0000_AB00, 1'b1);

    // contention: both valid for 4 cycles
    req0_valid = 1'b1; req0_ctrl = 2'b00; req0_shamt = 5'd0; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_ctrl = 2'b00; req1_shamt = 5'd0; req1_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
`ifdef SHIFT_ARB_RR_EN
      exp_id = i[0];
`else
      exp_id = 1'b0;
      #1;
      check("fp.rdy1lo", {31'b0, req1_ready}, 32'd0);
`endif
      tick();
      rsp_chk("cont", exp_id ? 32'h2222_2222 : 32'h1111_1111, exp_id);
    end
    // port 0 drops: port 1 now accepted
    req0_valid = 1'b0;
    #1;
    check("cont.rdy1", {31'b0, req1_ready}, 32'd1);
    tick();
    rsp_chk("cont.p1", 32'h2222_2222, 1'b1);

    // drain to EMPTY
    req1_valid = 1'b0;
    tick();
    check("drain.v", {31'b0, rsp_valid}, 32'd0);

    // backpressure: accept into EMPTY with rsp_ready low
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 2'b10; req0_shamt = 5'd8; req0_data = 32'h8000_0000;
    #1;
    check("bp.rdy0", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctrl = 2'b01; req1_shamt = 5'd4; req1_data = 32'h0000_00F0;
    for (int i = 0; i < 3; i++) begin
      #1;
      rsp_chk("bp.hold", 32'hFF80_0000, 1'b0);
      check("bp.rdy0lo", {31'b0, req0_ready}, 32'd0);
      check("bp.rdy1lo", {31'b0, req1_ready}, 32'd0);
      @(posedge clk);
    end
    #1;
    rsp_ready = 1'b1;
    #1;
    check("bp.rdy1", {31'b0, req1_ready}, 32'd1);
    tick();
    rsp_chk("bp.new", 32'h0000_000F, 1'b1);

    // reset while FULL with a fresh result pending
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 2'b00; req0_shamt = 5'd1; req0_data = 32'h0000_0005;
    tick();
    rsp_chk("mid.pre", 32'h0000_000A, 1'b0);
    req0_valid = 1'b0; rsp_ready = 1'b0; rst_n = 1'b0;
    tick();
    check("mid.v",  {31'b0, rsp_valid}, 32'd0);
    check("mid.d",  rsp_data, 32'd0);
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid.gone", {31'b0, rsp_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Time-shares a single combinational shifter between two requesters (port 0: integer execute path, port 1: CSR/bit-manipulation helper) using a valid/ready handshake. Accepted operations are shifted in the same cycle and returned through a one-entry registered response buffer tagged with the requester ID. Arbitration is round-robin, or fixed-priority when compiled that way. The block sits between the requesting units and the shared shifter instance in the execute stage.

## Interface
- WIDTH, 32: data width. Shift amount is always 5 bits.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req0_valid / req1_valid  input  1  requester n presents an operation.
- req0_ready / req1_ready  output  1  operation n is accepted this cycle when valid && ready.
- req0_ctrl / req1_ctrl  input  2  shift op: 00 LSL, 01 LSR, 10 ASR, 11 rotate-right.
- req0_shamt / req1_shamt  input  5  shift amount.
- req0_data / req1_data  input  WIDTH  operand.
- rsp_valid  output  1  result buffer holds a result.
- rsp_ready  input  1  consumer takes the result when rsp_valid && rsp_ready.
- rsp_data  output  WIDTH  shifted result.
- rsp_id  output  1  requester that issued the result (0 or 1).

## Operation
- Buffer states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = EMPTY || (rsp_valid && rsp_ready).
- Grant: only a valid requester is granted. If both are valid, the winner is the port that was not granted most recently (round-robin). The last-grant pointer updates only on an accepted transfer.
- reqN_ready = rst_n && can_accept && grant==N. At most one ready is high per cycle. Ready may depend combinationally on rsp_ready and both valids.
- On acceptance, the selected ctrl/shamt/data drive the shifter. OUT is captured into rsp_data, and rsp_id is set to the granted port. The state becomes or stays FULL.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on pop without accept.
  - FULL→FULL on pop+accept in the same cycle, or on no pop.
- Shift semantics, all WIDTH bits:
  - LSL: zero-fill.
  - LSR: zero-fill.
  - ASR: sign-fill from bit WIDTH-1.
  - Rotate-right: low WIDTH bits of {data,data} >> shamt.
  - shamt=0 returns data unchanged for every op.
- While FULL and rsp_ready=0, rsp_data and rsp_id are held stable, and both readies are 0.
- Requesters must hold valid and all payload signals stable until accepted. The block does not check this.

## Timing
- Reset (rst_n low at a rising edge):
  - Next cycle: rsp_valid=0, rsp_data=0, rsp_id=0, pointer set so port 0 wins the next tie.
  - Readies are 0 throughout reset.
- A reset during FULL discards the held result. No response is emitted for it.
- Latency: accept in cycle N → rsp_valid=1 with the result in cycle N+1.
- Throughput: one operation per cycle while rsp_ready stays high. There is no bubble on pop+accept.
- First cycle after reset release: if both ports are valid, port 0 is granted. If they stay valid, grants then alternate 0,1,0,1.
- A single valid requester is granted every cycle that can_accept=1, regardless of the pointer.

## Configuration
- SHIFT_ARB_RR_EN defined: round-robin arbitration as described above.
- SHIFT_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. The pointer register is removed. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with both valids high. Required: rsp_valid=0, rsp_data=0, rsp_id=0, both readies 0. After release, port 0 is granted first.
- Op coverage on port 0 with data=0x8000_00F1, shamt=4. Required results (rsp_id=0):
  - LSL → 0x0000_0F10
  - LSR → 0x0800_000F
  - ASR → 0xF800_000F
  - ROR → 0x1800_000F
- shamt=0 for each op on data=0xDEAD_BEEF. Required: every result is 0xDEAD_BEEF.
- Contention: both ports valid for 4 cycles, rsp_ready=1. Required:
  - With SHIFT_ARB_RR_EN: rsp_id sequence 0,1,0,1.
  - Without it: 0,0,0,0, and port 1 is not accepted until port 0 drops valid.
- Backpressure: accept an op, then hold rsp_ready=0 for 3 cycles. Required: rsp_valid=1 with rsp_data and rsp_id stable and both readies 0. When rsp_ready=1 with port 1 valid, the pop and the new accept occur in the same cycle, and the new result appears the next cycle.
- Reset mid-operation: assert rst_n=0 for one cycle while FULL. Required: rsp_valid=0 the next cycle, and the discarded result never appears.
